// File: rtl/dac_mux_sequencer_pkg.sv
// rtl/dac_mux_sequencer_pkg.sv - DAC command codes, init frames and sequencer state types
package dac_mux_sequencer_pkg;

  localparam int FRAME_W = 32;

  localparam logic [3:0] CMD_WR_UPD = 4'h3;
  localparam logic [3:0] CMD_RESET  = 4'h7;
  localparam logic [3:0] CMD_REF    = 4'h8;

  localparam logic [FRAME_W-1:0] FRAME_INIT_RST = {4'h0, CMD_RESET, 24'h000000};
  // Low data bit selects the internal reference on.
  localparam logic [FRAME_W-1:0] FRAME_INIT_REF = {4'h0, CMD_REF, 24'h000001};

  typedef enum logic [2:0] {
    ST_INIT_RST,
    ST_INIT_REF,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } seq_state_t;

  typedef enum logic [1:0] {
    K_RST,
    K_REF,
    K_SCAN
  } frame_kind_t;

  function automatic logic [FRAME_W-1:0] scan_frame(input logic [3:0] addr,
                                                    input logic [15:0] code16);
    return {4'h0, CMD_WR_UPD, addr, code16, 4'h0};
  endfunction

endpackage

// File: rtl/dac_mux_sequencer_spi_frame_tx.sv
// rtl/dac_mux_sequencer_spi_frame_tx.sv - 32-bit SPI frame shifter with sclk divider
module dac_mux_sequencer_spi_frame_tx
  import dac_mux_sequencer_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               sclk,
  output logic               mosi,
  output logic               cs,
  output logic               done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic               active;
  logic               phase;
  logic [DIV_W-1:0]   div_cnt;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               div_end;

  // phase=0 is the sclk-high half of a bit; the shift happens on the low->high turn.
  assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign cs      = ~active;
  assign sclk    = ~(active & phase);
  assign mosi    = active & shreg[FRAME_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (load) begin
          active  <= 1'b1;
          shreg   <= frame;
          phase   <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end else if (!div_end) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
        phase   <= ~phase;
        if (phase) begin
          if (bit_cnt == 5'd31) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            shreg   <= shreg << 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dac_mux_sequencer.sv
// rtl/dac_mux_sequencer.sv - AD56x8 init + channel scan sequencer with mux select and square-wave gate
module dac_mux_sequencer
  import dac_mux_sequencer_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4,
  parameter int MUX_W   = 2,
  parameter int SQ_HALF = 25,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              start,
  input  logic              ch_wr_en,
  input  logic [CH_W-1:0]   ch_wr_addr,
  input  logic [DATA_W-1:0] ch_wr_data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs,
  output logic [MUX_W-1:0]  mux_sel,
  output logic              sq_wave,
  output logic              init_done,
  output logic              busy
);

  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam int SQ_W  = $clog2(SQ_HALF + 1);

  seq_state_t         state, state_nx;
  frame_kind_t        kind;
  logic [CH_W-1:0]    ch;
  logic [GAP_W-1:0]   gap_cnt;
  logic [SQ_W-1:0]    sq_cnt;
  logic [DATA_W-1:0]  bank [NUM_CH];
  logic [DATA_W-1:0]  code_sel;
  logic [15:0]        code16;
  logic [FRAME_W-1:0] frame;
  logic               load, tx_done, pending, last_ch, gap_end, go;

  assign last_ch  = (ch == CH_W'(NUM_CH - 1));
  assign gap_end  = (gap_cnt == GAP_W'(CS_GAP - 1));
  assign go       = start | pending;
  // A write landing in the LOAD cycle of its own channel goes straight into the frame.
  assign code_sel = (ch_wr_en && ch_wr_addr == ch) ? ch_wr_data : bank[ch];
  assign code16   = 16'(code_sel) << (16 - DATA_W);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    frame    = scan_frame(4'(ch), code16);
    case (state)
      ST_INIT_RST: begin
        load     = 1'b1;
        frame    = FRAME_INIT_RST;
        state_nx = ST_SHIFT;
      end
      ST_INIT_REF: begin
        load     = 1'b1;
        frame    = FRAME_INIT_REF;
        state_nx = ST_SHIFT;
      end
      ST_IDLE:  if (go) state_nx = ST_LOAD;
      ST_LOAD: begin
        load     = 1'b1;
        state_nx = ST_SHIFT;
      end
      ST_SHIFT: if (tx_done) state_nx = ST_GAP;
      ST_GAP: begin
        if (gap_end) begin
          case (kind)
            K_RST:   state_nx = ST_INIT_REF;
            K_REF:   state_nx = ST_IDLE;
            default: state_nx = last_ch ? ST_IDLE : ST_LOAD;
          endcase
        end
      end
      default: state_nx = ST_INIT_RST;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state     <= ST_INIT_RST;
      kind      <= K_RST;
      ch        <= '0;
      gap_cnt   <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      mux_sel   <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_INIT_RST: kind <= K_RST;
        ST_INIT_REF: kind <= K_REF;
        ST_LOAD:     kind <= K_SCAN;
        ST_IDLE: begin
          if (go) begin
            ch      <= '0;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_end ? '0 : gap_cnt + GAP_W'(1);
          if (gap_end && kind == K_REF) init_done <= 1'b1;
          if (gap_end && kind == K_SCAN) begin
            if (last_ch) begin
              mux_sel <= mux_sel + MUX_W'(1);
              busy    <= 1'b0;
            end else begin
              ch <= ch + CH_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (start && !init_done) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
    end else if (ch_wr_en) begin
      bank[ch_wr_addr] <= ch_wr_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      sq_cnt  <= '0;
      sq_wave <= 1'b0;
    end else if (!init_done) begin
      sq_cnt  <= '0;
      sq_wave <= 1'b0;
    end else if (sq_cnt == SQ_W'(SQ_HALF - 1)) begin
      sq_cnt  <= '0;
      sq_wave <= ~sq_wave;
    end else begin
      sq_cnt <= sq_cnt + SQ_W'(1);
    end
  end

  dac_mux_sequencer_spi_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk_sys),
    .rst_n (rst_sys),
    .load  (load),
    .frame (frame),
    .sclk  (sclk),
    .mosi  (mosi),
    .cs    (cs),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_dac_mux_sequencer.sv
// tb/tb_dac_mux_sequencer.sv - randomized self-checking bench for dac_mux_sequencer
module tb_dac_mux_sequencer;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 12;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;
  localparam int MUX_W   = 2;
  localparam int SQ_HALF = 25;
  localparam int CH_W    = $clog2(NUM_CH);

  logic              clk_sys = 1'b0;
  logic              rst_sys;
  logic              start;
  logic              ch_wr_en;
  logic [CH_W-1:0]   ch_wr_addr;
  logic [DATA_W-1:0] ch_wr_data;
  logic              sclk, mosi, cs, sq_wave, init_done, busy;
  logic [MUX_W-1:0]  mux_sel;

  dac_mux_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
    .CS_GAP(CS_GAP), .MUX_W(MUX_W), .SQ_HALF(SQ_HALF)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .ch_wr_en(ch_wr_en),
    .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data), .sclk(sclk), .mosi(mosi),
    .cs(cs), .mux_sel(mux_sel), .sq_wave(sq_wave), .init_done(init_done), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bank contents, mux position and expected frame stream.
  logic [DATA_W-1:0] bank_m [NUM_CH];
  int                mux_m;
  logic [31:0]       exp_q [$];
  logic [31:0]       got_q [$];

  function automatic logic [31:0] model_frame(input int c, input logic [DATA_W-1:0] code);
    return (32'h3 << 24) | (32'(c) << 20) | (32'(code) << (20 - DATA_W));
  endfunction

  task automatic expect_channels(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) exp_q.push_back(model_frame(c, bank_m[c]));
  endtask

  // Frame decoder: mosi captured on sclk falling edges while cs is low.
  int          frames_started = 0;
  int          nbits = 0, low_cnt = 0, high_cnt = 0, sq_early = 0;
  bit          gap_ok = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [31:0] sh = '0;

  always @(negedge clk_sys) begin
    if (!rst_sys) begin
      nbits = 0; low_cnt = 0; high_cnt = 0; gap_ok = 0;
      prev_cs = 1'b1; prev_sclk = 1'b1;
    end else begin
      if (!init_done && sq_wave) sq_early++;
      if (!cs) begin
        if (prev_cs) begin
          frames_started++;
          if (gap_ok) check("cs_gap_min", 32'(high_cnt >= CS_GAP), 1);
          nbits = 0; low_cnt = 0; sh = '0;
        end
        low_cnt++;
        if (prev_sclk && !sclk) begin
          sh = {sh[30:0], mosi};
          nbits++;
        end
      end else begin
        if (!prev_cs) begin
          if (nbits == 32) begin
            got_q.push_back(sh);
            check("cs_low_len", low_cnt, 64 * CLK_DIV);
            check("mosi_idle", mosi, 0);
            gap_ok = 1;
          end else begin
            gap_ok = 0;
          end
          high_cnt = 0;
        end
        high_cnt++;
      end
      prev_cs = cs; prev_sclk = sclk;
    end
  end

  task automatic pulse_start();
    @(posedge clk_sys); #1 start = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0;
  endtask

  task automatic bank_write(input int c, input logic [DATA_W-1:0] v);
    @(posedge clk_sys); #1 ch_wr_en = 1'b1; ch_wr_addr = CH_W'(c); ch_wr_data = v;
    @(posedge clk_sys); #1 ch_wr_en = 1'b0;
    bank_m[c] = v;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (got_q.size() < n && k < 8000) begin @(negedge clk_sys); k++; end
    if (got_q.size() < n) check("timeout_frames", got_q.size(), n);
  endtask

  task automatic wait_started(input int n);
    int k = 0;
    while (frames_started < n && k < 8000) begin @(negedge clk_sys); k++; end
    if (frames_started < n) check("timeout_started", frames_started, n);
  endtask

  task automatic wait_not_busy();
    int k = 0;
    while (busy && k < 8000) begin @(negedge clk_sys); k++; end
    if (busy) check("timeout_busy", busy, 0);
    repeat (60) @(negedge clk_sys);
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic finish_scan(input string tag, input int base, input int nexp);
    wait_frames(nexp);
    wait_not_busy();
    check({tag, "_started"}, frames_started - base, nexp);
    compare_frames(tag);
    check({tag, "_mux"}, mux_sel, mux_m);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_scan(input string tag, input bit poke_busy);
    int base = frames_started;
    expect_channels(0, NUM_CH - 1);
    mux_m = (mux_m + 1) % (1 << MUX_W);
    pulse_start();
    check({tag, "_busy_rise"}, busy, 1);
    if (poke_busy) begin
      wait_started(base + 2);
      pulse_start();
    end
    finish_scan(tag, base, NUM_CH);
  endtask

  logic [DATA_W-1:0] table0 [NUM_CH] = '{12'h000, 12'h123, 12'h246, 12'h369,
                                         12'h48C, 12'h5AF, 12'h6D2, 12'hFFF};

  initial begin
    int hi, lo, k, base;
    rst_sys = 1'b0; start = 1'b0; ch_wr_en = 1'b0; ch_wr_addr = '0; ch_wr_data = '0;
    for (int c = 0; c < NUM_CH; c++) bank_m[c] = '0;
    mux_m = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_sclk", sclk, 1);
    check("rst_cs", cs, 1);
    check("rst_mosi", mosi, 0);
    check("rst_mux", mux_sel, 0);
    check("rst_sq", sq_wave, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);
    @(posedge clk_sys); #1 rst_sys = 1'b1;

    exp_q.push_back(32'h07000000);
    exp_q.push_back(32'h08000001);
    wait_frames(2);
    k = 0;
    while (!init_done && k < 200) begin @(negedge clk_sys); k++; end
    check("init_done", init_done, 1);
    compare_frames("init");
    check("sq_pre_init", sq_early, 0);

    k = 0;
    while (sq_wave !== 1'b0 && k < 200) begin @(negedge clk_sys); k++; end
    k = 0;
    while (sq_wave !== 1'b1 && k < 200) begin @(negedge clk_sys); k++; end
    hi = 0;
    while (sq_wave === 1'b1 && hi < 200) begin @(negedge clk_sys); hi++; end
    lo = 0;
    while (sq_wave === 1'b0 && lo < 200) begin @(negedge clk_sys); lo++; end
    check("sq_high_len", hi, SQ_HALF);
    check("sq_low_len", lo, SQ_HALF);

    for (int c = 0; c < NUM_CH; c++) bank_write(c, table0[c]);
    run_scan("scan_table", 1'b1);

    // Writes issued while ch3 shifts: ch3 keeps its old code, ch6 picks up the new one.
    base = frames_started;
    expect_channels(0, 3);
    pulse_start();
    wait_started(base + 4);
    bank_write(3, DATA_W'($urandom_range(0, (1 << DATA_W) - 1)));
    bank_write(6, DATA_W'($urandom_range(0, (1 << DATA_W) - 1)));
    expect_channels(4, NUM_CH - 1);
    mux_m = (mux_m + 1) % (1 << MUX_W);
    finish_scan("scan_midwr", base, NUM_CH);

    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 1) == 1) bank_write(c, DATA_W'($urandom_range(0, (1 << DATA_W) - 1)));
      run_scan("scan_rand", s[0]);
    end

    // Asynchronous reset in the middle of ch3.
    base = frames_started;
    pulse_start();
    wait_started(base + 4);
    k = 0;
    while (nbits < 16 && k < 2000) begin @(negedge clk_sys); k++; end
    #2 rst_sys = 1'b0;
    #1;
    check("midrst_cs", cs, 1);
    check("midrst_sclk", sclk, 1);
    check("midrst_mux", mux_sel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_init_done", init_done, 0);
    got_q.delete();
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) bank_m[c] = '0;
    mux_m = 0;
    repeat (3) @(posedge clk_sys);
    #1 rst_sys = 1'b1;
    base = frames_started;
    repeat (20) @(posedge clk_sys);
    pulse_start();
    repeat (100) @(posedge clk_sys);
    pulse_start();
    exp_q.push_back(32'h07000000);
    exp_q.push_back(32'h08000001);
    expect_channels(0, NUM_CH - 1);
    mux_m = 1;
    finish_scan("pending_scan", base, 2 + NUM_CH);
    check("pending_init_done", init_done, 1);
    check("sq_pre_init2", sq_early, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
